// File: rtl/fir_sample_packer_pkg.sv
// ============================================================================
// Module      : fir_sample_packer_pkg
// Description : Shared types and constants for the FIR sample-to-line packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_sample_packer_pkg;

  localparam int STATS_W     = 32;
  // Wide enough for any practical samples-per-line count; users truncate.
  localparam int META_FILL_W = 16;

  typedef struct packed {
    logic [META_FILL_W-1:0] fill;
    logic                   last;
  } line_meta_t;

  function automatic int calc_spl(input int line_w, input int sample_w);
    return line_w / sample_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_line_fifo.sv
// ============================================================================
// Module      : fir_line_fifo
// Description : Show-ahead line FIFO with registered head data/meta/valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_line_fifo
  import fir_sample_packer_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  line_meta_t        push_meta_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o,
  output line_meta_t        head_meta_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  line_meta_t        mem_meta_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              head_valid_q, head_valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  line_meta_t        head_meta_q, head_meta_d;
  logic              w_do_pop, w_do_push;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(w_do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(w_do_push);
    count_d  = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
  end

  // Head register: bypass the incoming line when it lands in the new head slot.
  always_comb begin
    head_valid_d = (count_d != '0);
    head_data_d  = '0;
    head_meta_d  = '0;
    if (w_do_push && (count_q == CNT_W'(w_do_pop))) begin
      head_data_d = push_data_i;
      head_meta_d = push_meta_i;
    end else if (head_valid_d) begin
      head_data_d = mem_data_q[rd_ptr_d];
      head_meta_d = mem_meta_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_data_q[wr_ptr_q] <= push_data_i;
      mem_meta_q[wr_ptr_q] <= push_meta_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_meta_q  <= '0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_meta_q  <= head_meta_d;
    end
  end

  assign head_valid_o = head_valid_q;
  assign head_data_o  = head_data_q;
  assign head_meta_o  = head_meta_q;

endmodule

`default_nettype wire

// File: rtl/fir_sample_packer.sv
// ============================================================================
// Module      : fir_sample_packer
// Description : Packs FIR samples into cache lines, buffers them in a line
//               FIFO and reports dropped lines. Define
//               FIR_SAMPLE_PACKER_STATS_EN to add saturating statistics ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sample_packer
  import fir_sample_packer_pkg::*;
#(
  parameter  int SAMPLE_WIDTH = 8,
  parameter  int LINE_WIDTH   = 512,
  parameter  int FIFO_DEPTH   = 4,
  localparam int SPL          = calc_spl(LINE_WIDTH, SAMPLE_WIDTH),
  localparam int FILL_W       = $clog2(SPL) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    flush,
  output logic [LINE_WIDTH-1:0]   line_data,
  output logic [FILL_W-1:0]       line_fill,
  output logic                    line_last,
  output logic                    line_valid,
  input  logic                    line_ready,
  output logic                    overflow,
  output logic                    flush_done
`ifdef FIR_SAMPLE_PACKER_STATS_EN
  ,
  output logic [STATS_W-1:0]      lines_out,
  output logic [STATS_W-1:0]      lines_dropped,
  output logic [STATS_W-1:0]      samples_in
`endif
);

  localparam int CNT_W = FILL_W - 1;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [LINE_WIDTH-1:0] asm_q, asm_d, w_line;
  logic                  w_close_full, w_close;
  line_meta_t            w_meta;

  logic                  stg_valid_q;
  logic [LINE_WIDTH-1:0] stg_data_q;
  line_meta_t            stg_meta_q;
  logic                  overflow_q, flush_done_q;

  logic                  w_fifo_full, w_fifo_empty, w_pop, w_drop;
  logic                  w_head_valid;
  logic [LINE_WIDTH-1:0] w_head_data;
  line_meta_t            w_head_meta;

  always_comb begin
    w_line = asm_q;
    if (sample_valid) begin
      w_line[cnt_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in;
    end
    w_close_full = sample_valid && (cnt_q == CNT_W'(SPL - 1));
    w_close      = w_close_full || (flush && (sample_valid || (cnt_q != '0)));
    w_meta.last  = flush;
    w_meta.fill  = w_close_full ? META_FILL_W'(SPL)
                                : META_FILL_W'(cnt_q) + META_FILL_W'(sample_valid);
    cnt_d        = w_close ? '0 : cnt_q + CNT_W'(sample_valid);
    asm_d        = w_close ? '0 : w_line;
  end

  // A closed line waits one cycle in the stage register before entering the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      asm_q        <= '0;
      stg_valid_q  <= 1'b0;
      stg_data_q   <= '0;
      stg_meta_q   <= '0;
      overflow_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      stg_valid_q  <= w_close;
      stg_data_q   <= w_close ? w_line : '0;
      stg_meta_q   <= w_close ? w_meta : '0;
      overflow_q   <= overflow_q || w_drop;
      flush_done_q <= flush;
    end
  end

  assign w_pop  = !w_fifo_empty && line_ready;
  assign w_drop = stg_valid_q && w_fifo_full && !w_pop;

  fir_line_fifo #(
    .DATA_W (LINE_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (stg_valid_q),
    .push_data_i  (stg_data_q),
    .push_meta_i  (stg_meta_q),
    .pop_i        (w_pop),
    .full_o       (w_fifo_full),
    .empty_o      (w_fifo_empty),
    .head_valid_o (w_head_valid),
    .head_data_o  (w_head_data),
    .head_meta_o  (w_head_meta)
  );

  assign line_valid = w_head_valid;
  assign line_data  = w_head_data;
  assign line_fill  = FILL_W'(w_head_meta.fill);
  assign line_last  = w_head_meta.last;
  assign overflow   = overflow_q;
  assign flush_done = flush_done_q;

`ifdef FIR_SAMPLE_PACKER_STATS_EN
  logic [STATS_W-1:0] lines_out_q, lines_dropped_q, samples_in_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lines_out_q     <= '0;
      lines_dropped_q <= '0;
      samples_in_q    <= '0;
    end else begin
      if (w_pop && !(&lines_out_q))            lines_out_q     <= lines_out_q + STATS_W'(1);
      if (w_drop && !(&lines_dropped_q))       lines_dropped_q <= lines_dropped_q + STATS_W'(1);
      if (sample_valid && !(&samples_in_q))    samples_in_q    <= samples_in_q + STATS_W'(1);
    end
  end

  assign lines_out     = lines_out_q;
  assign lines_dropped = lines_dropped_q;
  assign samples_in    = samples_in_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_sample_packer.sv
// ============================================================================
// Module      : tb_fir_sample_packer
// Description : Directed and randomized bench for fir_sample_packer against a
//               queue-based line model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_sample_packer;

  localparam int SW  = 8;
  localparam int LW  = 512;
  localparam int SPL = LW / SW;
  localparam int FD  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] line_data;
  logic [6:0]    line_fill;
  logic          line_last;
  logic          line_valid;
  logic          line_ready = 1'b0;
  logic          overflow;
  logic          flush_done;
`ifdef FIR_SAMPLE_PACKER_STATS_EN
  logic [31:0]   lines_out, lines_dropped, samples_in;
`endif

  always #5 clk = ~clk;

  fir_sample_packer #(
    .SAMPLE_WIDTH (SW),
    .LINE_WIDTH   (LW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .flush        (flush),
    .line_data    (line_data),
    .line_fill    (line_fill),
    .line_last    (line_last),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .overflow     (overflow),
    .flush_done   (flush_done)
`ifdef FIR_SAMPLE_PACKER_STATS_EN
    ,
    .lines_out     (lines_out),
    .lines_dropped (lines_dropped),
    .samples_in    (samples_in)
`endif
  );

  typedef struct {
    logic [LW-1:0] data;
    int            fill;
    bit            last;
  } line_t;

  line_t         mq[$];
  line_t         pend;
  bit            pend_v;
  logic [SW-1:0] cur[$];
  bit            ovf_exp, fd_exp;
  int            n_vec, n_fail;
  int            n_pop, n_drop, n_smp;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("line_valid", line_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("line_data", line_data, mq[0].data);
      chk("line_fill", line_fill, mq[0].fill);
      chk("line_last", line_last, mq[0].last);
    end
    chk("overflow", overflow, ovf_exp);
    chk("flush_done", flush_done, fd_exp);
  endtask

  task automatic model_clear();
    mq.delete();
    cur.delete();
    pend_v  = 0;
    ovf_exp = 0;
    fd_exp  = 0;
    n_pop   = 0;
    n_drop  = 0;
    n_smp   = 0;
  endtask

  // One clock: drive inputs, advance the line model at the edge, then compare.
  task automatic step(input bit sv, input logic [SW-1:0] s, input bit fl, input bit rdy);
    sample_valid = sv;
    sample_in    = s;
    flush        = fl;
    line_ready   = rdy;
    @(posedge clk);
    if (mq.size() > 0 && rdy) begin
      void'(mq.pop_front());
      n_pop++;
    end
    if (pend_v) begin
      if (mq.size() < FD) mq.push_back(pend);
      else begin
        ovf_exp = 1;
        n_drop++;
      end
    end
    pend_v = 0;
    if (sv) begin
      cur.push_back(s);
      n_smp++;
    end
    if (cur.size() == SPL || (fl && cur.size() > 0)) begin
      pend.data = '0;
      for (int k = 0; k < cur.size(); k++) pend.data[k*SW +: SW] = cur[k];
      pend.fill = cur.size();
      pend.last = fl;
      pend_v    = 1;
      cur.delete();
    end
    fd_exp = fl;
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_data"}, line_data, '0);
    chk({tag, "_fill"}, line_fill, '0);
    chk({tag, "_last"}, line_last, '0);
    chk({tag, "_valid"}, line_valid, '0);
    chk({tag, "_overflow"}, overflow, '0);
    chk({tag, "_flush_done"}, flush_done, '0);
  endtask

  task automatic do_reset();
    sample_valid = 0;
    flush        = 0;
    line_ready   = 0;
    reset        = 0;
    #2;
    check_reset_values("async_rst");
    @(posedge clk);
    #1;
    check_reset_values("held_rst");
    reset = 1;
    model_clear();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, '0, 0, rdy);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1;

    // Full line 0x00..0x3F
    for (int k = 0; k < SPL; k++) step(1, SW'(k), 0, 1);
    idle(3, 1);

    // Partial flush
    for (int k = 0; k < 5; k++) step(1, SW'(8'hA1 + k), 0, 1);
    step(0, '0, 1, 1);
    idle(3, 1);

    // Empty flush
    step(0, '0, 1, 1);
    idle(3, 1);

    // Flush coincident with the closing sample
    for (int k = 0; k < SPL - 1; k++) step(1, SW'($urandom), 0, 1);
    step(1, 8'h5A, 1, 1);
    idle(4, 1);

    // Overflow: six lines with the consumer stalled
    for (int k = 0; k < 6 * SPL; k++) step(1, SW'($urandom), 0, 0);
    idle(3, 0);
    idle(8, 1);
`ifdef FIR_SAMPLE_PACKER_STATS_EN
    chk("lines_dropped", lines_dropped, n_drop);
`endif

    // Reset mid-line, then a fresh line
    for (int k = 0; k < 30; k++) step(1, SW'($urandom), 0, 1);
    do_reset();
    for (int k = 0; k < SPL; k++) step(1, SW'(8'hC0 ^ k), 0, 1);
    idle(3, 1);

    // Randomized traffic with intermittent back-pressure and flushes
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) != 0), SW'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 9) < 6));
    end
    idle(12, 1);
`ifdef FIR_SAMPLE_PACKER_STATS_EN
    chk("lines_out", lines_out, n_pop);
    chk("lines_dropped_rand", lines_dropped, n_drop);
    chk("samples_in", samples_in, n_smp);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_sample_packer.md
# fir_sample_packer

Stream-to-line packer for the FIR accelerator's output path. It sits between the FIR output (`data_out`/`valid_out`) and the write-back engine. Successive FIR samples are collected into cache-line words, buffered in a small line FIFO, and handed to the write path with a valid/ready handshake. The FIR has no back-pressure, so this block absorbs stalls and reports drops rather than stalling the filter.

## Interface
- `SAMPLE_WIDTH`, 8, width of one FIR output sample
- `LINE_WIDTH`, 512, width of one cache line; must be a multiple of `SAMPLE_WIDTH`
- `FIFO_DEPTH`, 4, line FIFO depth in lines; power of two, ≥ 2

- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sample_in`  in  SAMPLE_WIDTH  FIR output sample
- `sample_valid`  in  1  sample_in valid this cycle; no ready returned
- `flush`  in  1  single-cycle pulse: close the current partial line
- `line_data`  out  LINE_WIDTH  packed line at FIFO head
- `line_fill`  out  $clog2(SPL)+1  number of valid samples in line_data (1..SPL)
- `line_last`  out  1  line was closed by flush
- `line_valid`  out  1  FIFO head valid
- `line_ready`  in  1  consumer accepts head when line_valid && line_ready
- `overflow`  out  1  sticky: at least one line dropped since reset
- `flush_done`  out  1  one-cycle pulse when the flush has been committed

## Operation
- SPL = LINE_WIDTH / SAMPLE_WIDTH (64 by default).
- Sample k of a line (0 = first received) occupies bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH], so the first sample sits at the LSB.
- Fill counter `cnt` runs 0..SPL-1 and is incremented on each accepted sample.
- Line close on the SPL-th sample: the assembled line is pushed with fill=SPL, last=0, and `cnt` returns to 0.
- Flush with cnt>0 and no sample: the partial line is pushed with fill=cnt, last=1. Unused upper bits are zero.
- Flush with cnt=0 and no sample: nothing is pushed. `flush_done` still pulses.
- Flush together with sample_valid: the sample is included first. If that sample completes the line, exactly one line is pushed, with fill=SPL and last=1.
- Push while the FIFO is full and no pop happens that cycle: the line is discarded, `overflow` is set, `cnt` still resets, and the assembly buffer is cleared.
- Push on a full FIFO with a pop in the same cycle: the push is accepted.
- Assembly buffer is zeroed whenever a line closes, so padding is always zero.
- Pop: the head advances when line_valid && line_ready. line_data, line_fill and line_last are held stable while line_valid && !line_ready.
- `overflow` is cleared only by reset.

## Timing
- All outputs are registered.
- Reset values: line_data=0, line_fill=0, line_last=0, line_valid=0, overflow=0, flush_done=0. Internal state on reset: cnt=0, FIFO empty.
- Closing sample or flush accepted at edge N, FIFO previously empty: line_valid=1 after edge N+1, i.e. one cycle of latency.
- flush_done is high for the cycle after the edge at which the flush is sampled.
- The FIFO sustains one push and one pop per cycle.
- Throughput is one sample per cycle indefinitely while line_ready is held high.
- Reset asserted mid-line or mid-handshake discards all partial and buffered data immediately. Outputs return to their reset values asynchronously.

## Configuration
- `FIR_SAMPLE_PACKER_STATS_EN` defined: adds three outputs, all 32-bit, saturating at all-ones, and cleared by reset:
  - `lines_out`, counting popped lines
  - `lines_dropped`, counting discarded lines
  - `samples_in`, counting accepted samples
- Not defined: these ports and counters do not exist. Functional behaviour is otherwise identical.

## Structure
- Package `fir_sample_packer_pkg` holds:
  - the SPL localparam function
  - `line_meta_t`, a struct of fill and last
  - the stats counter width constant
- One sub-module, `fir_line_fifo`: a synchronous show-ahead FIFO.
  - Carries LINE_WIDTH data plus `line_meta_t`.
  - Provides full/empty flags and registered head outputs.
- The top level contains the fill counter, assembly register, flush/close control and overflow logic.

## Test plan
- Full line: feed samples 0x00..0x3F on consecutive cycles with line_ready=1.
  - Exactly one line is produced.
  - line_data byte k equals k, fill=64, last=0.
  - line_valid rises one cycle after the 64th sample.
- Partial flush: feed 5 samples 0xA1..0xA5, then flush.
  - One line with bytes 0..4 = A1..A5, remaining bytes 0, fill=5, last=1.
  - flush_done pulses once.
- Empty flush: apply flush with cnt=0.
  - No line is produced, flush_done pulses, overflow stays 0.
- Flush coincident with the 64th sample: exactly one line, fill=64, last=1, and no zero-fill line follows.
- Overflow: hold line_ready=0 and stream 6×64 samples.
  - 4 lines are buffered, lines 5 and 6 are dropped, overflow=1.
  - Releasing ready then yields the first 4 lines intact and in order.
  - With STATS_EN: lines_dropped=2.
- Reset mid-line: after 30 samples, pulse reset low, then feed 64 fresh samples.
  - During reset, all outputs read their reset values.
  - The next line contains only the fresh samples, fill=64.
